// File: rtl/ysyx_24080006_trap_ctrl.sv
// ysyx_24080006 trap sequencer: drains the pipe, writes mepc/mcause/mstatus,
// then redirects fetch. Optional timer IRQ via YSYX_24080006_TIMER_IRQ_EN.
package ysyx_24080006_trap_pkg;
    typedef enum logic [11:0] {
        CSR_NONE    = 12'h000,
        CSR_MSTATUS = 12'h300,
        CSR_MTVEC   = 12'h305,
        CSR_MEPC    = 12'h341,
        CSR_MCAUSE  = 12'h342
    } csr_name_e;
endpackage

module ysyx_24080006_trap_ctrl
    import ysyx_24080006_trap_pkg::*;
#(
    parameter int TIMER_W   = 32,
    parameter int DRAIN_MAX = 15
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               exc_valid,
    input  logic [3:0]         exc_cause,
    input  logic               mret_valid,
    input  logic [31:0]        epc,
    output logic               exc_ready,
    output logic               mret_ready,
    input  logic [31:0]        csr_mtvec,
    input  logic [31:0]        csr_mepc,
    input  logic [31:0]        csr_mstatus,
    output logic               csr_we,
    output csr_name_e          csr_waddr,
    output logic [31:0]        csr_wdata,
    output logic               pipe_flush,
    input  logic               pipe_idle,
    output logic               redirect_valid,
    output logic [31:0]        redirect_pc,
    output logic               busy,
    output logic               drain_timeout,
    input  logic               tmr_we,
    input  logic [TIMER_W-1:0] tmr_wdata,
    output logic [TIMER_W-1:0] mtime
);

    typedef enum logic [2:0] {
        S_IDLE, S_DRAIN, S_MEPC, S_MCAUSE, S_MSTATUS, S_REDIR
    } state_e;

    typedef enum logic {K_TRAP, K_MRET} kind_e;

    localparam int CNT_W = $clog2(DRAIN_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DRAIN_MAX);

    state_e            state_q, state_d;
    kind_e             kind_q, kind_d;
    logic [31:0]       cause_q, cause_d;
    logic [29:0]       pc_q, pc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              tmo_q, tmo_d;
    logic              irq_pending;
    logic              unused_bits;

`ifdef YSYX_24080006_TIMER_IRQ_EN
    logic [TIMER_W-1:0] mtime_q, mtimecmp_q;

    // free-running mtime; mtimecmp load is independent of the increment
    always_ff @(posedge clock) begin
        if (reset) begin
            mtime_q    <= '0;
            mtimecmp_q <= '1;
        end else begin
            mtime_q <= mtime_q + TIMER_W'(1);
            if (tmr_we) mtimecmp_q <= tmr_wdata;
        end
    end

    assign irq_pending = (mtime_q >= mtimecmp_q);
    assign mtime       = mtime_q;
    assign unused_bits = ^{csr_mtvec[1:0], epc[1:0]};
`else
    assign irq_pending = 1'b0;
    assign mtime       = '0;
    assign unused_bits = ^{csr_mtvec[1:0], epc[1:0], tmr_we, tmr_wdata};
`endif

    // sequencer state and latched trap context
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            kind_q  <= K_TRAP;
            cause_q <= '0;
            pc_q    <= '0;
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            cause_q <= cause_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
        end
    end

    // next-state and per-state outputs
    always_comb begin
        state_d        = state_q;
        kind_d         = kind_q;
        cause_d        = cause_q;
        pc_d           = pc_q;
        cnt_d          = cnt_q;
        tmo_d          = tmo_q;
        exc_ready      = 1'b0;
        mret_ready     = 1'b0;
        csr_we         = 1'b0;
        csr_waddr      = CSR_NONE;
        csr_wdata      = '0;
        pipe_flush     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        busy           = (state_q != S_IDLE);
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (exc_valid) begin
                    exc_ready = 1'b1;
                    cause_d   = {28'b0, exc_cause};
                    pc_d      = epc[31:2];
                    kind_d    = K_TRAP;
                    state_d   = S_DRAIN;
                end else if (irq_pending && csr_mstatus[3]) begin
                    cause_d = 32'h8000_0007;
                    pc_d    = epc[31:2];
                    kind_d  = K_TRAP;
                    state_d = S_DRAIN;
                end else if (mret_valid) begin
                    mret_ready = 1'b1;
                    kind_d     = K_MRET;
                    state_d    = S_DRAIN;
                end
            end
            S_DRAIN: begin
                pipe_flush = 1'b1;
                if (pipe_idle) begin
                    state_d = (kind_q == K_TRAP) ? S_MEPC : S_MSTATUS;
                end else begin
                    if (cnt_q == CNT_LAST) tmo_d = 1'b1;
                    if (cnt_q != CNT_SAT) cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_MEPC: begin
                pipe_flush = 1'b1;
                csr_we     = 1'b1;
                csr_waddr  = CSR_MEPC;
                csr_wdata  = {pc_q, 2'b00};
                state_d    = S_MCAUSE;
            end
            S_MCAUSE: begin
                pipe_flush = 1'b1;
                csr_we     = 1'b1;
                csr_waddr  = CSR_MCAUSE;
                csr_wdata  = cause_q;
                state_d    = S_MSTATUS;
            end
            S_MSTATUS: begin
                pipe_flush = 1'b1;
                csr_we     = 1'b1;
                csr_waddr  = CSR_MSTATUS;
                csr_wdata  = csr_mstatus;
                if (kind_q == K_TRAP) begin
                    csr_wdata[7] = csr_mstatus[3];
                    csr_wdata[3] = 1'b0;
                end else begin
                    csr_wdata[3] = csr_mstatus[7];
                    csr_wdata[7] = 1'b1;
                end
                csr_wdata[12:11] = 2'b11;
                state_d = S_REDIR;
            end
            S_REDIR: begin
                pipe_flush     = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = (kind_q == K_TRAP) ?
                                 {csr_mtvec[31:2], 2'b00} : csr_mepc;
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // no handshake is granted while reset is held
        if (reset) begin
            exc_ready  = 1'b0;
            mret_ready = 1'b0;
        end
    end

    assign drain_timeout = tmo_q;

endmodule
